// File: rtl/shift_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared definitions for the shift sequencer slice: FSM state encoding and
// the direction / mode constants used on the request and Shifter buses.
// ---------------------------------------------------------------------------
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_LEFT    = 1'b1;
    localparam logic DIR_RIGHT   = 1'b0;

    localparam logic MODE_ROTATE = 1'b1;
    localparam logic MODE_SHIFT  = 1'b0;

endpackage

// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
// Bundles the request handshake, the Shifter control/data lines and the
// result handshake of the shift sequencer. Signal names are seen from the
// sequencer side (i_* = into the sequencer, o_* = out of it).
//   slave  : the sequencer itself
//   master : the environment (ALU control path + Shifter)
// Optional: SHIFT_SEQUENCER_ABORT_EN adds i_abort.
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
    parameter int N = 8
);
    // request handshake
    logic         i_valid;
    logic         o_ready;
    logic         i_direction;
    logic         i_rotate;
    logic [N-1:0] i_amount;
    logic [N-1:0] i_value;
    // Shifter control / data
    logic         o_shift_start;
    logic         o_shift_direction;
    logic         o_shift_rotate;
    logic [N-1:0] o_shift_iterations;
    logic [N-1:0] o_shift_value;
    logic [N-1:0] i_shift_value;
    // result handshake
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_result;
`ifdef SHIFT_SEQUENCER_ABORT_EN
    logic         i_abort;
`endif

    modport slave (
        input  i_valid, i_direction, i_rotate, i_amount, i_value,
        input  i_shift_value, i_ready,
`ifdef SHIFT_SEQUENCER_ABORT_EN
        input  i_abort,
`endif
        output o_ready, o_shift_start, o_shift_direction, o_shift_rotate,
        output o_shift_iterations, o_shift_value, o_valid, o_result
    );

    modport master (
        output i_valid, i_direction, i_rotate, i_amount, i_value,
        output i_shift_value, i_ready,
`ifdef SHIFT_SEQUENCER_ABORT_EN
        output i_abort,
`endif
        input  o_ready, o_shift_start, o_shift_direction, o_shift_rotate,
        input  o_shift_iterations, o_shift_value, o_valid, o_result
    );

endinterface

// File: rtl/shift_sequencer_normalizer.sv
// ---------------------------------------------------------------------------
// shift_amount_normalizer
// Combinational reduction of a requested amount to the number of Shifter
// iterations actually needed.
//   rotate      : requested mode (MODE_ROTATE / MODE_SHIFT)
//   amount      : requested amount
//   eff_amount  : rotate -> amount mod N; shift -> amount unchanged
//   zero_result : shift by N or more positions (result is all zeros)
// ---------------------------------------------------------------------------
module shift_amount_normalizer
    import shift_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         rotate,
    input  logic [N-1:0] amount,
    output logic [N-1:0] eff_amount,
    output logic         zero_result
);

    localparam int LOG2N = $clog2(N);
    localparam logic [N-1:0] AMOUNT_MASK = {{(N-LOG2N){1'b0}}, {LOG2N{1'b1}}};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        eff_amount  = amount;
        zero_result = 1'b0;
        if (rotate == MODE_ROTATE) begin
            // N is a power of two, so mod N is just the low log2(N) bits.
            eff_amount = amount & AMOUNT_MASK;
        end else begin
            // Any bit at or above log2(N) means the amount is >= N.
            zero_result = |amount[N-1:LOG2N];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Upstream controller for the Shifter: accepts a shift/rotate request,
// starts the Shifter, counts the iterations and returns the Shifter output
// captured after exactly the requested number of shifts.
// Ports:
//   i_clock : clock, rising edge
//   i_reset : asynchronous, active-high reset
//   bus     : shift_sequencer_if.slave (request, Shifter and result lines)
// Parameter N: operand/amount width, power of two >= 2.
// Optional: define SHIFT_SEQUENCER_ABORT_EN to add bus.i_abort, which drops
// an in-flight request (LOAD/SHIFT) and returns to IDLE without a result.
// ---------------------------------------------------------------------------
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    shift_sequencer_if.slave     bus
);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_width
        $error("shift_sequencer: N must be a power of two >= 2");
    end

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_next;
    logic         req_direction, req_rotate, req_zero;
    logic [N-1:0] req_value, req_amount;
    logic [N-1:0] remaining, remaining_dec, result;
    logic [N-1:0] norm_amount;
    logic         norm_zero;
    logic         abort_hit;

    shift_amount_normalizer #(.N(N)) u_normalizer (
        .rotate      (bus.i_rotate),
        .amount      (bus.i_amount),
        .eff_amount  (norm_amount),
        .zero_result (norm_zero)
    );

    // Decrement as an add of all-ones, the same form the shared Adder uses.
    assign remaining_dec = remaining + {N{1'b1}};

`ifdef SHIFT_SEQUENCER_ABORT_EN
    assign abort_hit = bus.i_abort && (state == LOAD || state == SHIFT);
`else
    assign abort_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state and handshake/strobe outputs
    always_comb begin
        state_next        = state;
        bus.o_ready       = 1'b0;
        bus.o_valid       = 1'b0;
        bus.o_shift_start = 1'b0;
        case (state)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) state_next = LOAD;
            end
            LOAD: begin
                bus.o_shift_start = 1'b1;
                if (req_zero || req_amount == '0) state_next = DONE;
                else                              state_next = SHIFT;
            end
            SHIFT: begin
                if (remaining == ONE) state_next = DONE;
            end
            DONE: begin
                bus.o_valid = 1'b1;
                if (bus.i_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort_hit) state_next = IDLE;
    end

    // Request registers, iteration counter and result capture
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            req_direction <= 1'b0;
            req_rotate    <= 1'b0;
            req_zero      <= 1'b0;
            req_value     <= '0;
            req_amount    <= '0;
            remaining     <= '0;
            result        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        req_direction <= bus.i_direction;
                        req_rotate    <= bus.i_rotate;
                        req_value     <= bus.i_value;
                        req_amount    <= norm_amount;
                        req_zero      <= norm_zero;
                    end
                end
                LOAD: begin
                    if (!abort_hit) begin
                        if (req_zero)               result    <= '0;
                        else if (req_amount == '0)  result    <= bus.i_shift_value;
                        else                        remaining <= req_amount;
                    end
                end
                SHIFT: begin
                    if (!abort_hit) begin
                        if (remaining == ONE) result    <= bus.i_shift_value;
                        else                  remaining <= remaining_dec;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shifter configuration follows the registered request in every state.
    assign bus.o_shift_direction  = req_direction;
    assign bus.o_shift_rotate     = req_rotate;
    assign bus.o_shift_iterations = req_amount;
    assign bus.o_shift_value      = req_value;
    assign bus.o_result           = result;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
// Scoreboard bench for shift_sequencer (N=8) with a behavioural Shifter.
// The driver pushes hand-computed results and latencies on acceptance; a
// monitor pops and compares on every result handshake.
// Optional: SHIFT_SEQUENCER_ABORT_EN enables the abort scenario.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    localparam int N = 8;

    typedef struct {
        logic       dir;
        logic       rot;
        logic [7:0] amt;
        logic [7:0] val;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] result;
        int         lat;
        int         accept_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];
    int   first_valid_cyc;
    logic seen_valid;

    shift_sequencer_if #(.N(N)) bus ();

    shift_sequencer #(.N(N)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural Shifter ----------------
    // On start the operand is loaded already shifted once (or unchanged for
    // zero iterations); one more shift per cycle until the count is reached.
    // While start is high the operand is passed straight through.
    logic [7:0] sh_reg;
    int         sh_cnt;

    function automatic logic [7:0] shift1(input logic [7:0] v, input logic dir, input logic rot);
        logic [7:0] r;
        if (dir == DIR_LEFT) r = {v[6:0], (rot == MODE_ROTATE) ? v[7] : 1'b0};
        else                 r = {(rot == MODE_ROTATE) ? v[0] : 1'b0, v[7:1]};
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.o_shift_start) begin
            sh_reg <= (bus.o_shift_iterations == 8'd0) ? bus.o_shift_value
                    : shift1(bus.o_shift_value, bus.o_shift_direction, bus.o_shift_rotate);
            sh_cnt <= 1;
        end else if (sh_cnt < int'(bus.o_shift_iterations)) begin
            sh_reg <= shift1(sh_reg, bus.o_shift_direction, bus.o_shift_rotate);
            sh_cnt <= sh_cnt + 1;
        end
    end

    assign bus.i_shift_value = bus.o_shift_start ? bus.o_shift_value : sh_reg;

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            seen_valid = 1'b0;
        end else begin
            if (bus.o_valid && !seen_valid) begin
                first_valid_cyc = cyc;
                seen_valid      = 1'b1;
            end
            if (bus.o_valid) check("ready_low_in_done", int'(bus.o_ready), 0);
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", int'(bus.o_result), int'(e.result));
                    check("latency", first_valid_cyc - e.accept_cyc, e.lat);
                end
                seen_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input vec_t v);
        logic s;
        int   c;
        logic accepted;
        @(posedge clk);
        #1;
        bus.i_direction = v.dir;
        bus.i_rotate    = v.rot;
        bus.i_amount    = v.amt;
        bus.i_value     = v.val;
        bus.i_valid     = 1'b1;
        accepted = 1'b0;
        c = 0;
        for (int n = 0; n < 100 && !accepted; n++) begin
            @(negedge clk);
            s = bus.o_ready;
            c = cyc;
            @(posedge clk);
            if (s) accepted = 1'b1;
        end
        if (accepted) sb.push_back('{result: v.exp, lat: v.lat, accept_cyc: c});
        else          check("accept_timeout", 0, 1);
        #1 bus.i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (n < 200 && !(sb.size() == 0 && !bus.o_valid && !bus.i_valid)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check(name, 0, 1);
    endtask

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va, vb;
        int   n;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        sh_reg   = 8'h00;
        sh_cnt   = 0;
        seen_valid = 1'b0;
        first_valid_cyc = 0;
        rst             = 1'b0;
        bus.i_valid     = 1'b0;
        bus.i_direction = 1'b0;
        bus.i_rotate    = 1'b0;
        bus.i_amount    = 8'h00;
        bus.i_value     = 8'h00;
        bus.i_ready     = 1'b1;
`ifdef SHIFT_SEQUENCER_ABORT_EN
        bus.i_abort     = 1'b0;
`endif

        //          dir        rot          amt    val    exp    lat
        vecs[0]  = '{DIR_LEFT,  MODE_SHIFT,  8'd3, 8'h81, 8'h08, 5};
        vecs[1]  = '{DIR_LEFT,  MODE_ROTATE, 8'd1, 8'h81, 8'h03, 3};
        vecs[2]  = '{DIR_RIGHT, MODE_ROTATE, 8'd1, 8'h81, 8'hC0, 3};
        vecs[3]  = '{DIR_RIGHT, MODE_SHIFT,  8'd4, 8'hF0, 8'h0F, 6};
        vecs[4]  = '{DIR_LEFT,  MODE_SHIFT,  8'd0, 8'h5A, 8'h5A, 2};
        vecs[5]  = '{DIR_LEFT,  MODE_SHIFT,  8'd9, 8'hFF, 8'h00, 2};
        vecs[6]  = '{DIR_LEFT,  MODE_ROTATE, 8'd9, 8'h81, 8'h03, 3};
        vecs[7]  = '{DIR_RIGHT, MODE_ROTATE, 8'd8, 8'h3C, 8'h3C, 2};
        vecs[8]  = '{DIR_RIGHT, MODE_SHIFT,  8'd7, 8'h80, 8'h01, 9};
        vecs[9]  = '{DIR_LEFT,  MODE_SHIFT,  8'd8, 8'h01, 8'h00, 2};
        vecs[10] = '{DIR_RIGHT, MODE_ROTATE, 8'd3, 8'hA5, 8'hB4, 5};

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("reset_o_ready",     int'(bus.o_ready),            1);
        check("reset_o_valid",     int'(bus.o_valid),            0);
        check("reset_shift_start", int'(bus.o_shift_start),      0);
        check("reset_o_result",    int'(bus.o_result),           0);
        check("reset_iterations",  int'(bus.o_shift_iterations), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed vectors, back to back
        foreach (vecs[i]) send(vecs[i]);
        drain("drain_vectors");

        // Backpressure: result held for 5 cycles, second request waits
        @(posedge clk);
        #1 bus.i_ready = 1'b0;
        va = vecs[3];
        vb = vecs[6];
        send(va);
        fork
            send(vb);
        join_none
        n = 0;
        @(negedge clk);
        while (!bus.o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("bp_valid_timeout", 0, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_o_valid",  int'(bus.o_valid),  1);
            check("bp_o_ready",  int'(bus.o_ready),  0);
            check("bp_o_result", int'(bus.o_result), 8'h0F);
        end
        @(posedge clk);
        #1 bus.i_ready = 1'b1;
        drain("drain_backpressure");

        // Asynchronous reset in the middle of SHIFT
        va = '{DIR_LEFT, MODE_SHIFT, 8'd7, 8'h01, 8'h80, 9};
        send(va);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check("midreset_o_valid",  int'(bus.o_valid),  0);
        check("midreset_o_ready",  int'(bus.o_ready),  1);
        check("midreset_o_result", int'(bus.o_result), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        send(vecs[0]);
        drain("drain_after_reset");

`ifdef SHIFT_SEQUENCER_ABORT_EN
        // Abort while in SHIFT: no result, back to IDLE
        va = '{DIR_LEFT, MODE_SHIFT, 8'd5, 8'h01, 8'h20, 7};
        send(va);
        @(posedge clk);
        #1 bus.i_abort = 1'b1;
        @(posedge clk);
        #1 bus.i_abort = 1'b0;
        sb.delete();
        repeat (10) begin
            @(negedge clk);
            check("abort_no_valid", int'(bus.o_valid), 0);
        end
        check("abort_ready", int'(bus.o_ready), 1);
        send(vecs[1]);
        drain("drain_after_abort");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
